muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (8..64, even).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: in_valid_i  input  1  request valid; in_ready_o  output  1  unit can accept.
REQ-004 SHALL have ports: op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have ports: a_i  input  WIDTH  rs1 operand; b_i  input  WIDTH  rs2 operand.
REQ-006 SHALL have ports: out_valid_o  output  1  result valid; out_ready_i  input  1  consumer accepts; result_o  output  WIDTH  result.
REQ-007 SHALL have port flush_i  input  1  abort in-flight operation.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE; in_ready_o = 1 only in IDLE.
REQ-009 SHALL capture op_i, a_i, b_i on a cycle with in_valid_i and in_ready_o both high, then enter BUSY.
REQ-010 SHALL iterate exactly WIDTH cycles in BUSY, one radix-2 step per cycle, counted by a $clog2(WIDTH+1)-bit counter; after the last step, enter DONE.
REQ-011 SHALL assert out_valid_o only in DONE; result_o holds stable while out_valid_o is high and out_ready_i is low.
REQ-012 SHALL leave DONE for IDLE on the cycle out_ready_i is high; no new request is accepted in that same cycle.
REQ-013 SHALL perform multiply as shift-add on operand magnitudes with sign correction; MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits of the 2*WIDTH product (signed*signed, signed*unsigned, unsigned*unsigned).
REQ-014 SHALL perform divide as restoring division on magnitudes; quotient rounds toward zero; remainder sign equals dividend sign.
REQ-015 SHALL, for divisor 0: DIV/DIVU return all ones, REM/REMU return a_i.
REQ-016 SHALL, for signed overflow (a_i = most-negative, b_i = -1): DIV returns a_i, REM returns 0.
REQ-017 SHALL drive result_o = 0 whenever out_valid_o is low.
REQ-018 SHALL, when flush_i is high, return to IDLE next cycle from any state, discarding operation and result; flush_i overrides in_valid_i and out_ready_i in the same cycle.

Reset
REQ-019 SHALL on rst high asynchronously enter IDLE: in_ready_o = 1, out_valid_o = 0, result_o = 0, counter = 0, operand/accumulator registers = 0.
REQ-020 SHALL, on reset asserted mid-BUSY or in DONE, discard the operation; no out_valid_o pulse follows reset release.

Configuration
REQ-021 SHALL honour macro MULDIV_EARLY_OUT_EN.
REQ-022 SHALL with MULDIV_EARLY_OUT_EN defined: divide-by-zero, signed overflow, and multiply with either operand 0 go IDLE -> DONE directly (out_valid_o one cycle after acceptance), results per REQ-015/016 or 0.
REQ-023 SHALL without MULDIV_EARLY_OUT_EN: all operations take full WIDTH BUSY cycles; results are identical.

Verification (WIDTH=32)
REQ-024 SHALL cover: MUL a=7, b=-3 -> result 0xFFFFFFEB, out_valid_o exactly 33 cycles after accept cycle.
REQ-025 SHALL cover: MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-026 SHALL cover: DIV a=-7, b=2 -> -3 (0xFFFFFFFD); REM same -> -1 (0xFFFFFFFF); DIVU a=100, b=7 -> 14.
REQ-027 SHALL cover: DIV a=5, b=0 -> 0xFFFFFFFF, REMU -> 5; DIV a=0x80000000, b=-1 -> 0x80000000, REM -> 0; with MULDIV_EARLY_OUT_EN latency 1 cycle, without it 33.
REQ-028 SHALL cover: hold out_ready_i low 10 cycles in DONE -> result_o stable, in_ready_o low; then out_ready_i high -> IDLE next cycle.
REQ-029 SHALL cover: flush_i at BUSY cycle 5, and rst mid-BUSY -> IDLE next cycle (immediately for rst), no out_valid_o; subsequent DIVU 9/3 -> 3.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN: trivial operations (divide by zero, signed
// overflow, multiply by zero) skip the BUSY phase and complete one cycle after acceptance.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  input  logic             flush_i
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0]  hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0]  lo_q, lo_d;       // multiplier -> product low half / dividend -> quotient
  logic              neg_q, neg_d;     // final result needs two's-complement negation
  logic [WIDTH-1:0]  result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  // Request decode: operand signedness, magnitudes and result sign
  logic             in_a_sgn, in_b_sgn, in_a_neg, in_b_neg, in_neg;
  logic [WIDTH-1:0] in_a_mag, in_b_mag;

  always_comb begin
    in_a_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV) || (op_i == OP_REM);
    in_b_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    in_a_neg = in_a_sgn && a_i[WIDTH-1];
    in_b_neg = in_b_sgn && b_i[WIDTH-1];
    in_a_mag = in_a_neg ? ((~a_i) + WIDTH'(1)) : a_i;
    in_b_mag = in_b_neg ? ((~b_i) + WIDTH'(1)) : b_i;
    // Remainder follows the dividend sign; a zero divisor yields an all-ones
    // quotient that must not be negated, so the quotient sign is masked then.
    if (!op_i[2]) begin
      in_neg = in_a_neg ^ in_b_neg;
    end else if (op_i[1]) begin
      in_neg = in_a_neg;
    end else begin
      in_neg = (in_a_neg ^ in_b_neg) && (b_i != '0);
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Detect operations whose result is known at acceptance time
  logic             early_hit;
  logic [WIDTH-1:0] early_res;

  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (op_i[2]) begin
      if (b_i == '0) begin
        early_hit = 1'b1;
        early_res = op_i[1] ? a_i : '1;
      end else if (in_b_sgn && (a_i == MOST_NEG) && (b_i == '1)) begin
        early_hit = 1'b1;
        early_res = op_i[1] ? '0 : a_i;
      end
    end else if ((a_i == '0) || (b_i == '0)) begin
      early_hit = 1'b1;
      early_res = '0;
    end
  end
`endif

  // One radix-2 iteration of the active operation plus final result formatting
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH-1:0] fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    // Partial remainder stays below 2*divisor, so bit WIDTH of the difference is its sign
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) begin
        hi_step = div_diff[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo_q[0]) begin
        {hi_step, lo_step} = {mul_sum, lo_q[WIDTH-1:1]};
      end else begin
        {hi_step, lo_step} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end
    end

    prod     = {hi_step, lo_step};
    prod_fix = neg_q ? ((~prod) + PW'(1)) : prod;
    quot_fix = neg_q ? ((~lo_step) + WIDTH'(1)) : lo_step;
    rem_fix  = neg_q ? ((~hi_step) + WIDTH'(1)) : hi_step;

    case (op_q)
      OP_MUL:                        fin_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fix[PW-1:WIDTH];
      OP_DIV, OP_DIVU:               fin_res = quot_fix;
      default:                       fin_res = rem_fix;
    endcase
  end

  // Next-state, datapath and output register inputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      result_d    = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            state_d    = BUSY;
            in_ready_d = 1'b0;
            cnt_d      = '0;
            op_d       = op_i;
            neg_d      = in_neg;
            hi_d       = '0;
            opnd_d     = op_i[2] ? in_b_mag : in_a_mag;
            lo_d       = op_i[2] ? in_a_mag : in_b_mag;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              state_d     = DONE;
              result_d    = early_res;
              out_valid_d = 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d     = DONE;
            cnt_d       = '0;
            result_d    = fin_res;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_d     = IDLE;
            result_d    = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): directed and random operations checked
// against an arithmetic reference model, plus handshake, flush and reset cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        flush_i;

  int checks;
  int errors;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .flush_i     (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        sa, sb, ua, ub, p;
    logic signed [31:0] as_v, bs_v, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as_v = a;
    bs_v = b;
    case (op)
      3'd0: begin p = 64'($signed(sa) * $signed(sb)); return p[31:0]; end
      3'd1: begin p = 64'($signed(sa) * $signed(sb)); return p[63:32]; end
      3'd2: begin p = 64'($signed(sa) * $signed(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = as_v / bs_v;
        return q;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = as_v % bs_v;
        return q;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Expected cycles from acceptance edge to out_valid_o
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op < 3'd4 && (a == 32'd0 || b == 32'd0)) return 1;
    if (op >= 3'd4 && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`else
    if (op == 3'd7 && a == 32'd1 && b == 32'd1 && 1 == 0) return 0;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns after the acceptance edge (at the following negedge)
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_i       = op;
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // Wait (bounded) for out_valid_o; lat counts edges since acceptance
  task automatic wait_valid(output int lat, output logic zero_ok);
    lat     = 1;
    zero_ok = 1'b1;
    while (!out_valid_o && lat < 100) begin
      if (result_o !== 32'd0) zero_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp_res;
    int          lat;
    logic        zero_ok;
    exp_res = ref_model(op, a, b);
    send(op, a, b);
    wait_valid(lat, zero_ok);
    check({tag, "/latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
    check({tag, "/result"}, 64'(result_o), 64'(exp_res));
    check({tag, "/zero_when_invalid"}, 64'(zero_ok), 64'(1));
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check({tag, "/back_to_idle"}, 64'({in_ready_o, out_valid_o, result_o}),
          64'({1'b1, 1'b0, 32'd0}));
  endtask

  initial begin
    int          lat;
    logic        zero_ok;
    logic        hold_ok;
    logic        seen_valid;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    op_i        = 3'd0;
    a_i         = 32'd0;
    b_i         = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/outputs", 64'({in_ready_o, out_valid_o, result_o}), 64'({1'b1, 1'b0, 32'd0}));
    rst = 1'b0;
    @(negedge clk);
    check("reset/released", 64'({in_ready_o, out_valid_o}), 64'({1'b1, 1'b0}));

    // Directed vectors
    run_op("mul_7_m3",       3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op("mulhu_max",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulhsu_m1",      3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("mulh_min_min",   3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op("div_m7_2",       3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op("rem_m7_2",       3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op("divu_100_7",     3'd5, 32'd100,        32'd7);
    run_op("div_5_0",        3'd4, 32'd5,          32'd0);
    run_op("div_m5_0",       3'd4, 32'hFFFF_FFFB,  32'd0);
    run_op("remu_5_0",       3'd7, 32'd5,          32'd0);
    run_op("rem_m5_0",       3'd6, 32'hFFFF_FFFB,  32'd0);
    run_op("div_ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("rem_ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op("mul_zero",       3'd0, 32'd0,          32'h1234_5678);

    // Back-pressure in DONE: result held, no acceptance, leave on out_ready
    send(3'd5, 32'd1000, 32'd7);
    wait_valid(lat, zero_ok);
    check("hold/latency", 64'(lat), 64'(ref_latency(3'd5, 32'd1000, 32'd7)));
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = (i % 2) == 0;
      if (!out_valid_o || in_ready_o || result_o !== ref_model(3'd5, 32'd1000, 32'd7))
        hold_ok = 1'b0;
      @(negedge clk);
    end
    check("hold/stable", 64'(hold_ok), 64'(1));
    check("hold/result", 64'(result_o), 64'(ref_model(3'd5, 32'd1000, 32'd7)));
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    @(negedge clk);
    check("hold/release_idle", 64'({in_ready_o, out_valid_o}), 64'({1'b1, 1'b0}));
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    @(negedge clk);
    check("hold/no_same_cycle_accept", 64'({in_ready_o, out_valid_o}), 64'({1'b1, 1'b0}));

    // Flush at BUSY cycle 5, with in_valid also asserted
    send(3'd0, 32'd12345, 32'd678);
    repeat (4) @(negedge clk);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk);
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush/idle", 64'({in_ready_o, out_valid_o, result_o}), 64'({1'b1, 1'b0, 32'd0}));
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid_o || !in_ready_o) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("flush/no_result", 64'(seen_valid), 64'(0));

    // Asynchronous reset mid-BUSY
    send(3'd5, 32'd77, 32'd5);
    repeat (7) @(negedge clk);
    check("rst/busy_before", 64'(in_ready_o), 64'(0));
    rst = 1'b1;
    #1;
    check("rst/immediate_idle", 64'({in_ready_o, out_valid_o, result_o}),
          64'({1'b1, 1'b0, 32'd0}));
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid_o) seen_valid = 1'b1;
      @(negedge clk);
    end
    check("rst/no_result", 64'(seen_valid), 64'(0));
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3);

    // Randomized operations with biased corner operands
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'd0;
        4: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op("random", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
